// File: rtl/i4001_rom.sv
// i4001_rom -- behavioural model of an MCS-4 4001 ROM + I/O port chip.
//
// The chip follows the CPU's 8-phase instruction cycle:
//   A1  A2  A3  M1  M2  X1  X2  X3
// It assembles an 8-bit ROM address from A1/A2 and checks the chip number at A3.
// When selected, it returns the instruction byte on M1 (OPR) and M2 (OPA).
// A 4-bit I/O port is selected by SRC (cm_rom at X2) and is accessed by
// WRR/RDR, whose OPA is flagged by cm_rom at M2.
//
// Parameters
//   CHIP_ID   chip number compared at A3 and at SRC X2
//   IO_MASK   per-bit port direction, 1 = output, 0 = input
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   sync                CPU sync, high during X3; realigns the phase counter
//   cm_rom              CPU ROM command line
//   dbus_in             resolved 4-bit system data bus
//   dbus_out, dbus_oe   data driven by this chip, and its valid flag
//   io_in, io_out       port input pins, and the masked output latch
//   prog_we/addr/data   ROM load port, active in any phase and while unlocked
module i4001_rom #(
  parameter logic [3:0] CHIP_ID = 4'h0,
  parameter logic [3:0] IO_MASK = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sync,
  input  logic       cm_rom,
  input  logic [3:0] dbus_in,
  output logic [3:0] dbus_out,
  output logic       dbus_oe,
  input  logic [3:0] io_in,
  output logic [3:0] io_out,
  input  logic       prog_we,
  input  logic [7:0] prog_addr,
  input  logic [7:0] prog_data
);

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_t;

  // Port opcodes. Any OPA other than WRR/RDR is treated as a no-op.
  localparam logic [3:0] OPA_NOP = 4'h0;
  localparam logic [3:0] OPA_WRR = 4'h2;
  localparam logic [3:0] OPA_RDR = 4'hA;

  phase_t      phase_q, phase_d;
  logic        locked_q, locked_d;
  logic [7:0]  addr_q;
  logic        sel_q;
  logic [7:0]  fetch_q;
  logic        io_sel_q;
  logic [3:0]  io_opa_q;
  logic        resync;

  // A sync that does not arrive in X3 abandons the instruction in flight.
  assign resync = sync && (phase_q != PH_X3);

  // ---------------------------------------------------------------------------
  // ROM array
  // ---------------------------------------------------------------------------
  logic [7:0] rom [256];

  // NOTE: the ROM array has no reset. Clearing 256 bytes would cost a lot of
  // logic, and reset must not disturb a program that is already loaded.
  always_ff @(posedge clk) begin
    if (prog_we) rom[prog_addr] <= prog_data;
  end

  // ---------------------------------------------------------------------------
  // Phase tracker: state register / next state
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) assignments, so every flop
  // samples pre-edge values. As a result, a ROM write and a fetch to the same
  // address on the same edge return the old byte. For the same reason, SRC
  // and WRR/RDR on the same X2 both see the previous io_sel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= PH_A1;
      locked_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      locked_q <= locked_d;
    end
  end

  // NOTE: every combinational output gets a default value first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    phase_d  = phase_t'(phase_q + 3'd1);
    locked_d = locked_q;
    if (sync) begin
      phase_d  = PH_A1;
      locked_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Address, fetch and I/O port datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= 8'h00;
      sel_q    <= 1'b0;
      fetch_q  <= 8'h00;
      io_sel_q <= 1'b0;
      io_opa_q <= OPA_NOP;
      io_out   <= 4'h0;
    end else if (resync) begin
      sel_q    <= 1'b0;
      io_opa_q <= OPA_NOP;
    end else if (locked_q) begin
      unique case (phase_q)
        PH_A1: addr_q[3:0] <= dbus_in;
        PH_A2: addr_q[7:4] <= dbus_in;
        PH_A3: begin
          sel_q   <= (dbus_in == CHIP_ID);
          fetch_q <= rom[addr_q];
        end
        PH_M2: io_opa_q <= cm_rom ? dbus_in : OPA_NOP;
        PH_X2: begin
          if (cm_rom) io_sel_q <= (dbus_in == CHIP_ID);
          if (io_sel_q && (io_opa_q == OPA_WRR)) io_out <= dbus_in & IO_MASK;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Bus drive
  // ---------------------------------------------------------------------------
  // The driver is gated by locked_q, which is cleared asynchronously, so reset
  // releases the bus at once. It is also gated by !sync, which keeps the bus
  // released during a phase that is being abandoned by an early sync.
  always_comb begin
    dbus_oe  = 1'b0;
    dbus_out = 4'h0;
    if (locked_q && !sync) begin
      unique case (phase_q)
        PH_M1: if (sel_q) begin
          dbus_oe  = 1'b1;
          dbus_out = fetch_q[7:4];
        end
        PH_M2: if (sel_q) begin
          dbus_oe  = 1'b1;
          dbus_out = fetch_q[3:0];
        end
        PH_X2: if (io_sel_q && (io_opa_q == OPA_RDR)) begin
          dbus_oe  = 1'b1;
          dbus_out = (io_in & ~IO_MASK) | (io_out & IO_MASK);
        end
        default: ;
      endcase
    end
  end

endmodule
